// File: rtl/countdown_timer_4_bit.sv
// countdown_timer_4_bit
// Loadable 4-bit countdown timer wrapped around an external combinational
// decrementor (decrementor_4_bit). The current count is driven out on dec_in
// and the decremented value comes back on dec_out; this block never computes
// count-1 itself. Control: load > stop > start. Outputs: busy (RUN level) and
// a registered one-cycle done pulse on expiry.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   When defined, expiry in RUN with a non-zero reload value reloads the count
//   and keeps running, pulsing done once per period instead of stopping.
//   When undefined, the timer is single-shot and the reload value has no
//   observable effect, so no reload register is kept.
module countdown_timer_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] dec_out,
    output logic [3:0] dec_in,
    output logic [3:0] count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count_next;
    logic       done_next;
    logic       reload_pulse;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [3:0] reload;
    logic [3:0] reload_next;
`endif

    // The decrementor operand is always the live registered count.
    assign dec_in = count;
    assign busy   = (state == RUN);

    // State, count and done flag registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Reload value captured on every load, used to restart the count on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= 4'd0;
        end else begin
            reload <= reload_next;
        end
    end
`endif

    // Next-state and next-count decode; load overrides everything, then stop, then start.
    always_comb begin
        state_next   = state;
        count_next   = count;
        reload_pulse = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_next  = reload;
`endif
        if (load) begin
            count_next = load_val;
            state_next = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_next = load_val;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != 4'd0) begin
                            state_next = RUN;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = HOLD;
                    end else begin
                        count_next = dec_out;
                        if (count == 4'd1) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload != 4'd0) begin
                                count_next   = reload;
                                reload_pulse = 1'b1;
                            end else begin
                                state_next = DONE;
                            end
`else
                            state_next = DONE;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end
                default: begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end
            endcase
        end
    end

    // done is registered so it is high exactly for the cycle spent in DONE
    // or the cycle after an auto-reload.
    always_comb begin
        done_next = (state_next == DONE) || reload_pulse;
    end

endmodule

// File: tb/tb_countdown_timer_4_bit.sv
// Testbench for countdown_timer_4_bit.
// The external decrementor is modelled as a plain 4-bit subtract-by-one.
// Expected count/busy/done values are hand-derived per scenario, pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped after the edge.
module tb_countdown_timer_4_bit;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic [3:0] dec_out;
    logic [3:0] dec_in;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int errors;
    int checks;

    typedef struct packed {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       sp;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } step_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];

    countdown_timer_4_bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .dec_out  (dec_out),
        .dec_in   (dec_in),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    // Reference decrementor sitting outside the timer.
    assign dec_out = dec_in - 4'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic ld, input logic [3:0] lv, input logic st,
                                 input logic sp, input logic [3:0] cnt, input logic bsy,
                                 input logic dn);
        step_t s;
        s.ld  = ld;
        s.lv  = lv;
        s.st  = st;
        s.sp  = sp;
        s.cnt = cnt;
        s.bsy = bsy;
        s.dn  = dn;
        return s;
    endfunction

    task automatic test_reset();
        step_t steps[$];
        exp_t  e;
        load = 1'b0; load_val = 4'd0; start = 1'b0; stop = 1'b0;
        rst_n = 1'b0;
        #2;
        exp_q.push_back('{4'd0, 1'b0, 1'b0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
            errors++;
            $display("[TB] FAIL reset_initial: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        steps.push_back(mk(1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL reset_pre step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
        // Asynchronous reset in the middle of a clock period.
        #2;
        rst_n = 1'b0;
        exp_q.push_back('{4'd0, 1'b0, 1'b0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
            errors++;
            $display("[TB] FAIL reset_async: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
        end
        #1;
        rst_n = 1'b1;
        steps.delete();
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0));
        steps.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL reset_post step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_countdown();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0));
        for (int k = 4; k >= 1; k--) begin
            steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'(k), 1'b1, 1'b0));
        end
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL countdown step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_pause();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL pause step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_zero();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL zero step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_max();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0));
        for (int k = 14; k >= 1; k--) begin
            steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'(k), 1'b1, 1'b0));
        end
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL max step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_simultaneous();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0));
        steps.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        steps.push_back(mk(1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0));
        steps.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL simultaneous step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
        steps.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0));
        for (int p = 0; p < 3; p++) begin
            steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
            steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0));
            steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1));
        end
        steps.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        steps.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        foreach (steps[i]) begin
            load = steps[i].ld; load_val = steps[i].lv; start = steps[i].st; stop = steps[i].sp;
            exp_q.push_back('{steps[i].cnt, steps[i].bsy, steps[i].dn});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || dec_in !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                errors++;
                $display("[TB] FAIL auto_reload step %0d: got count=%0d dec_in=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, dec_in, busy, done, e.cnt, e.bsy, e.dn);
            end
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask
`endif

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown();
        test_pause();
        test_max();
        test_simultaneous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
